// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared pipeline definitions for the hazard/flush controller:
//               FSM state encoding, the zero-register constant and the
//               load-use compare helper.
// Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_JRFL    = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load in EX whose destination is read by the instruction in ID.
    // Register zero never creates a dependency.
    function automatic logic load_use_hit(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt,
        input logic [4:0] rt_ex,
        input logic       mem_to_reg_ex,
        input logic       reg_wr_ex
    );
        return mem_to_reg_ex && reg_wr_ex && (rt_ex != REG_ZERO) &&
               ((rt_ex == rs) || (uses_rt && (rt_ex == rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Enabled up-counter that holds at all-ones instead of wrapping.
//               Updates on the falling clock edge, like the pipeline registers.
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment when enabled unless already at the maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard/flush controller. Detects load-use hazards,
//               resolves taken branch / j / jal / jr and mispredictions in EX,
//               drives stall and flush controls, and keeps saturating
//               stall/flush event counters for performance debug.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int JR_FLUSH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             uses_rt,
    input  logic [4:0]       rttoEX,
    input  logic             MentoRegtoEX,
    input  logic             RegWrtoEX,
    input  logic             BtoEX,
    input  logic             br_cond,
    input  logic             JtoEX,
    input  logic             jartoEX,
    input  logic             jrtoEX,
    input  logic             pred_miss,
    output logic             loadad,
    output logic             pc_wr_en,
    output logic             ifid_wr_en,
    output logic             B_J_jump,
    output logic             Jr_jump,
    output logic             jumpSuccess,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Remaining JRFL cycles after the entry cycle; JR_FLUSH is at most 3.
    localparam logic [1:0] JR_INIT = 2'(JR_FLUSH - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] jr_cnt_q, jr_cnt_d;

    logic w_lu;
    logic w_bj;
    logic w_loadad;
    logic w_bj_flush;
    logic w_jr_flush;
    logic w_pm_flush;
    logic w_flush_evt;

    assign w_lu = load_use_hit(rs, rt, uses_rt, rttoEX, MentoRegtoEX, RegWrtoEX);
    assign w_bj = (BtoEX && br_cond) || JtoEX || jartoEX;

    // Next-state and same-cycle outputs; priority jr > bj > pred_miss > load-use.
    always_comb begin
        state_d     = state_q;
        jr_cnt_d    = jr_cnt_q;
        w_loadad    = 1'b0;
        w_bj_flush  = 1'b0;
        w_jr_flush  = 1'b0;
        w_pm_flush  = 1'b0;
        w_flush_evt = 1'b0;
        case (state_q)
            ST_JRFL: begin
                // Tail of a jr flush: everything else is ignored.
                w_jr_flush = 1'b1;
                jr_cnt_d   = jr_cnt_q - 2'd1;
                if (jr_cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                // RUN and LDSTALL share flush handling; only RUN may stall.
                state_d = ST_RUN;
                if (jrtoEX) begin
                    w_jr_flush  = 1'b1;
                    w_flush_evt = 1'b1;
                    if (JR_FLUSH > 1) begin
                        state_d  = ST_JRFL;
                        jr_cnt_d = JR_INIT;
                    end
                end else if (w_bj) begin
                    w_bj_flush  = 1'b1;
                    w_flush_evt = 1'b1;
                end else if (pred_miss) begin
                    w_pm_flush  = 1'b1;
                    w_flush_evt = 1'b1;
                end else if ((state_q == ST_RUN) && w_lu) begin
                    w_loadad = 1'b1;
                    state_d  = ST_LDSTALL;
                end
            end
        endcase
    end

    // FSM state and jr flush countdown.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            jr_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            jr_cnt_q <= jr_cnt_d;
        end
    end

    assign loadad      = w_loadad;
    assign pc_wr_en    = ~w_loadad;
    assign ifid_wr_en  = ~w_loadad;
    assign B_J_jump    = w_bj_flush;
    assign Jr_jump     = w_jr_flush;
    assign jumpSuccess = w_pm_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_loadad),
        .cnt   (stall_cnt)
    );

    // Counts flush events on entry only, so a multi-cycle jr counts once.
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_flush_evt),
        .cnt   (flush_cnt)
    );

endmodule
`default_nettype wire
